// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: request/acknowledge bundle between one requester and the
// I/O bus arbiter. One instance per requester.
//   master modport: the requesting FSM (drives req/wr/addr/wdata)
//   slave  modport: the arbiter (returns ack/rdata)
interface io_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, wr, addr, wdata, input ack, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-requester sequencer for the shared 8-bit programmed-I/O
// bus. Grants the bus to one requester, runs the full ior_/iow_ strobe cycle
// and returns a one-cycle ack (with read data for reads).
//
// Sequence per access (edge 0 = grant, S = STROBE_CYCLES):
//   edge 0      : addr driven, write data driven
//   edge 1..1+S : strobe low
//   edge 1+S    : strobe high, read data captured, ack high
//   edge 2+S    : ack low, data released, back in IDLE
//
// Optional feature macro: IOARB_RR_EN
//   defined   -> round-robin between the two requesters on contention
//   undefined -> fixed priority, requester 0 always wins contention
module io_bus_arbiter #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset_,
  io_bus_arbiter_if.slave m0,
  io_bus_arbiter_if.slave m1,
  output logic [15:0]     addr,
  inout  wire  [7:0]      data,
  output logic            ior_,
  output logic            iow_
);

  // Strobe width is carried in a 4-bit counter; 0 would give no strobe at all.
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("io_bus_arbiter: STROBE_CYCLES must be in 1..15");
  end

  // Counter value on the last strobe-low cycle.
  localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STRB, END, HOLD} state_t;

  state_t      state_reg,  state_next;
  logic [3:0]  cnt_reg,    cnt_next;
  logic        sel_reg,    sel_next;     // requester owning the current access
  logic        wr_reg,     wr_next;
  logic [7:0]  wdata_reg,  wdata_next;
  logic [15:0] addr_reg,   addr_next;
  logic        drive_reg,  drive_next;   // data output enable
  logic        ior_reg,    ior_next;
  logic        iow_reg,    iow_next;
  logic [1:0]  ack_reg,    ack_next;
  logic [7:0]  rdata0_reg, rdata0_next;
  logic [7:0]  rdata1_reg, rdata1_next;

  logic any_req;
  logic pick;                            // winner if a grant happens now

  assign any_req = m0.req | m1.req;

`ifdef IOARB_RR_EN
  logic last_reg, last_next;             // requester served most recently

  // On contention the requester that was not served last wins.
  assign pick = (m0.req && m1.req) ? ~last_reg : m1.req;
`else
  // Requester 0 wins whenever it is asking; requester 1 only when alone.
  assign pick = ~m0.req;
`endif

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sel_next    = sel_reg;
    wr_next     = wr_reg;
    wdata_next  = wdata_reg;
    addr_next   = addr_reg;
    drive_next  = drive_reg;
    ior_next    = 1'b1;
    iow_next    = 1'b1;
    ack_next    = 2'b00;
    rdata0_next = rdata0_reg;
    rdata1_next = rdata1_reg;
`ifdef IOARB_RR_EN
    last_next   = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          // Latch the winner's request so it may drop req mid-access.
          sel_next   = pick;
          wr_next    = pick ? m1.wr    : m0.wr;
          addr_next  = pick ? m1.addr  : m0.addr;
          wdata_next = pick ? m1.wdata : m0.wdata;
          drive_next = pick ? m1.wr    : m0.wr;
          cnt_next   = 4'd0;
          state_next = STRB;
        end
      end
      STRB: begin
        ior_next = wr_reg;
        iow_next = ~wr_reg;
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = 4'd0;
          state_next = END;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      END: begin
        // Strobe rises on this edge (defaults); read data is sampled here.
        if (!wr_reg) begin
          if (sel_reg) begin
            rdata1_next = data;
          end else begin
            rdata0_next = data;
          end
        end
        ack_next   = sel_reg ? 2'b10 : 2'b01;
`ifdef IOARB_RR_EN
        last_next  = sel_reg;
`endif
        state_next = HOLD;
      end
      HOLD: begin
        // Address is kept; only the data driver lets go of the bus.
        drive_next = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset forces strobes high and releases data at once.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      sel_reg    <= 1'b0;
      wr_reg     <= 1'b0;
      wdata_reg  <= 8'h00;
      addr_reg   <= 16'h0000;
      drive_reg  <= 1'b0;
      ior_reg    <= 1'b1;
      iow_reg    <= 1'b1;
      ack_reg    <= 2'b00;
      rdata0_reg <= 8'h00;
      rdata1_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      wr_reg     <= wr_next;
      wdata_reg  <= wdata_next;
      addr_reg   <= addr_next;
      drive_reg  <= drive_next;
      ior_reg    <= ior_next;
      iow_reg    <= iow_next;
      ack_reg    <= ack_next;
      rdata0_reg <= rdata0_next;
      rdata1_reg <= rdata1_next;
    end
  end

`ifdef IOARB_RR_EN
  // Last-served pointer; starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end
`endif

  assign addr     = addr_reg;
  assign ior_     = ior_reg;
  assign iow_     = iow_reg;
  assign data     = drive_reg ? wdata_reg : 8'hzz;
  assign m0.ack   = ack_reg[0];
  assign m1.ack   = ack_reg[1];
  assign m0.rdata = rdata0_reg;
  assign m1.rdata = rdata1_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenarios plus randomized two-requester traffic,
// checked every cycle against a transaction-level model of the bus sequence.
// A pullup on data makes a released bus read as FF.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
  localparam int S    = 3;       // strobe width used for the DUT
  localparam int SPAN = 3 + S;   // cycles per access at full throughput
`ifdef IOARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock  = 1'b0;
  logic reset_ = 1'b1;
  always #5 clock = ~clock;

  io_bus_arbiter_if m0_if ();
  io_bus_arbiter_if m1_if ();
  logic [15:0] addr;
  wire  [7:0]  data;
  logic        ior_;
  logic        iow_;

  io_bus_arbiter #(.STROBE_CYCLES(S)) dut (
    .clock (clock),
    .reset_(reset_),
    .m0    (m0_if),
    .m1    (m1_if),
    .addr  (addr),
    .data  (data),
    .ior_  (ior_),
    .iow_  (iow_)
  );

  // Bus device: answers a read with a value derived from the address.
  function automatic logic [7:0] dev_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign data = ior_ ? 8'hzz : dev_val(addr);
  pullup pu_data (data);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        mb_busy = 1'b0;
  int          mk = 0;               // edges since the grant edge
  logic        t_w = 1'b0;
  logic        t_wr = 1'b0;
  logic [15:0] t_addr = 16'h0;
  logic [7:0]  t_wdata = 8'h0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_rdata [2];
  logic        m_last = 1'b1;
  logic [1:0]  ack_now = 2'b00;

  task automatic model_step();
    if (!reset_) begin
      mb_busy = 1'b0; mk = 0; m_addr = 16'h0;
      m_rdata[0] = 8'h00; m_rdata[1] = 8'h00; m_last = 1'b1;
    end else if (mb_busy) begin
      mk++;
      if (mk == S + 1) begin
        if (!t_wr) m_rdata[t_w] = dev_val(t_addr);
        m_last = t_w;
      end
      if (mk == S + 2) mb_busy = 1'b0;
    end else if (m0_if.req || m1_if.req) begin
      if (m0_if.req && m1_if.req) t_w = RR ? ~m_last : 1'b0;
      else                        t_w = m1_if.req;
      t_wr    = t_w ? m1_if.wr    : m0_if.wr;
      t_addr  = t_w ? m1_if.addr  : m0_if.addr;
      t_wdata = t_w ? m1_if.wdata : m0_if.wdata;
      m_addr  = t_addr;
      mb_busy = 1'b1;
      mk      = 0;
    end
  endtask

  task automatic compare();
    logic       e_ior, e_iow, e_ack0, e_ack1;
    logic [7:0] e_data;
    e_ior  = !(mb_busy && !t_wr && mk >= 1 && mk <= S);
    e_iow  = !(mb_busy &&  t_wr && mk >= 1 && mk <= S);
    e_ack0 = mb_busy && mk == S + 1 && t_w == 1'b0;
    e_ack1 = mb_busy && mk == S + 1 && t_w == 1'b1;
    if (mb_busy && t_wr && mk <= S + 1) e_data = t_wdata;
    else if (!e_ior)                    e_data = dev_val(m_addr);
    else                                e_data = 8'hFF;
    check("ior_",   ior_, e_ior);
    check("iow_",   iow_, e_iow);
    check("addr",   addr, m_addr);
    check("data",   data, e_data);
    check("ack0",   m0_if.ack, e_ack0);
    check("ack1",   m1_if.ack, e_ack1);
    check("rdata0", m0_if.rdata, m_rdata[0]);
    check("rdata1", m1_if.rdata, m_rdata[1]);
    ack_now = {e_ack1, e_ack0};
    if (e_ack0 || e_ack1)
      $display("txn m%0d %s addr=%h data=%h t=%0t", t_w, t_wr ? "wr" : "rd", t_addr,
               t_wr ? t_wdata : m_rdata[t_w], $time);
  endtask

  // Model advances on each posedge; outputs are compared on the following negedge.
  initial begin
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare();
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_master(input logic ackd, inout logic req, inout logic wr,
                             inout logic [15:0] a, inout logic [7:0] wd);
    if (!req) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b1; wr = 1'($urandom_range(0, 1)); a = 16'($urandom); wd = 8'($urandom);
      end
    end else if (ackd) begin
      if ($urandom_range(0, 1) == 0) req = 1'b0;
      else begin wr = 1'($urandom_range(0, 1)); a = 16'($urandom); wd = 8'($urandom); end
    end else if ($urandom_range(0, 39) == 0) begin
      req = 1'b0;
    end
  endtask

  logic [5:0] strb_pat = 6'b110001;   // strobe level after edge n, n=0..5 (S=3)
  logic [5:0] ack_pat  = 6'b010000;   // ack after edge n
  int ack_who [4];
  int ack_at  [4];
  int na;
  int lat;

  initial begin
    m0_if.req = 1'b0; m0_if.wr = 1'b0; m0_if.addr = 16'h0; m0_if.wdata = 8'h0;
    m1_if.req = 1'b0; m1_if.wr = 1'b0; m1_if.addr = 16'h0; m1_if.wdata = 8'h0;
    #2 reset_ = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check("rst_ior",    ior_, 1'b1);
    check("rst_iow",    iow_, 1'b1);
    check("rst_data",   data, 8'hFF);
    check("rst_addr",   addr, 16'h0000);
    check("rst_ack",    {m1_if.ack, m0_if.ack}, 2'b00);
    check("rst_rdata0", m0_if.rdata, 8'h00);
    check("rst_rdata1", m1_if.rdata, 8'h00);
    @(negedge clock); #1 reset_ = 1'b1;
    @(negedge clock); #1;

    // Read by master 0 at 0101; device returns 5A.
    m0_if.req = 1'b1; m0_if.wr = 1'b0; m0_if.addr = 16'h0101;
    for (int n = 0; n < SPAN; n++) begin
      @(negedge clock); #2;
      check("rd_ior",  ior_, strb_pat[n]);
      check("rd_iow",  iow_, 1'b1);
      check("rd_ack0", m0_if.ack, ack_pat[n]);
      check("rd_ack1", m1_if.ack, 1'b0);
      if (n == S + 1) begin
        check("rd_rdata0", m0_if.rdata, 8'h5A);
        check("rd_rdata1", m1_if.rdata, 8'h00);
        m0_if.req = 1'b0;
      end
    end

    // Read by master 0 at 0203, req dropped right after the grant edge.
    m0_if.req = 1'b1; m0_if.addr = 16'h0203;
    for (int n = 0; n < SPAN; n++) begin
      @(negedge clock); #2;
      if (n == 0) m0_if.req = 1'b0;
      check("drop_ack0", m0_if.ack, ack_pat[n]);
      if (n == S + 1) check("drop_rdata0", m0_if.rdata, 8'h5B);
    end

    // Write by master 1: 0121 <- C3.
    m1_if.req = 1'b1; m1_if.wr = 1'b1; m1_if.addr = 16'h0121; m1_if.wdata = 8'hC3;
    for (int n = 0; n < SPAN; n++) begin
      @(negedge clock); #2;
      check("wr_iow",  iow_, strb_pat[n]);
      check("wr_ior",  ior_, 1'b1);
      check("wr_addr", addr, 16'h0121);
      check("wr_data", data, (n <= S + 1) ? 8'hC3 : 8'hFF);
      check("wr_ack1", m1_if.ack, ack_pat[n]);
      if (n == S + 1) m1_if.req = 1'b0;
    end

    // Contention: both masters hold read requests.
    m0_if.wr = 1'b0; m0_if.addr = 16'h0010; m1_if.wr = 1'b0; m1_if.addr = 16'h0020;
    m0_if.req = 1'b1; m1_if.req = 1'b1;
    na = 0;
    for (int n = 0; n < 28; n++) begin
      @(negedge clock); #2;
      if (m0_if.ack || m1_if.ack) begin
        if (na < 4) begin ack_who[na] = m1_if.ack ? 1 : 0; ack_at[na] = n; end
        na++;
        if (na == 4) begin m0_if.req = 1'b0; m1_if.req = 1'b0; end
      end
    end
    check("cont_count", na, 4);
    if (na >= 4) begin
      check("cont_g0", ack_who[0], 0);
      check("cont_g1", ack_who[1], RR ? 1 : 0);
      check("cont_g2", ack_who[2], 0);
      check("cont_g3", ack_who[3], RR ? 1 : 0);
      check("cont_first", ack_at[0], 4);
      for (int i = 1; i < 4; i++) check("cont_gap", ack_at[i] - ack_at[i-1], SPAN);
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;

    // Reset during the strobe of a master-0 write.
    @(negedge clock); #1;
    m0_if.req = 1'b1; m0_if.wr = 1'b1; m0_if.addr = 16'h0330; m0_if.wdata = 8'h3C;
    repeat (3) @(negedge clock);
    #2;
    check("rs_in_strobe", iow_, 1'b0);
    reset_ = 1'b0;
    #1;
    check("rs_iow",  iow_, 1'b1);
    check("rs_data", data, 8'hFF);
    check("rs_ack",  {m1_if.ack, m0_if.ack}, 2'b00);
    check("rs_addr", addr, 16'h0000);
    @(negedge clock); #1 reset_ = 1'b1;
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock); #2;
      if (m0_if.ack) begin lat = n; m0_if.req = 1'b0; break; end
    end
    check("rs_restart_lat", lat, S + 1);
    m0_if.req = 1'b0;

    // Randomized traffic from both masters.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock); #1;
      rand_master(ack_now[0], m0_if.req, m0_if.wr, m0_if.addr, m0_if.wdata);
      rand_master(ack_now[1], m1_if.req, m1_if.wr, m1_if.addr, m1_if.wdata);
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    repeat (10) @(negedge clock);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master sequencer for the shared 8-bit programmed-I/O bus: addr, bidirectional data, ior_ and iow_. Two requesters (for example a polling reader on one interface and a result writer on another) post single-byte read/write requests. The block grants the bus to one requester at a time, runs the complete strobe cycle on that requester's behalf and returns a one-cycle acknowledge with read data. It sits between the processing FSMs and the I/O port decoders, so no requester drives the bus directly.

## Interface
- STROBE_CYCLES, 1: cycles ior_/iow_ are held low per access; legal range 1..15; 0 is illegal.
- clock  input  1  system clock; all state changes on posedge.
- reset_  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from master 0 / 1; level, held until the matching ack.
- wr0 / wr1  input  1  1 = write, 0 = read; must be stable while req is high.
- addr0 / addr1  input  16  I/O address; must be stable while req is high.
- wdata0 / wdata1  input  8  write byte; must be stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata0 / rdata1  output  8  read byte; updated only by that master's read; holds its value otherwise.
- addr  output  16  bus address.
- data  inout  8  bus data; driven only during a write, Z otherwise.
- ior_ / iow_  output  1  active-low read / write strobes.

## Operation
- Clock port is named clock; reset port is reset_. Reset is asynchronous and active-low.
- Reset values: ior_=1, iow_=1, data=Z (drive off), addr=16'h0000, ack0=ack1=0, rdata0=rdata1=8'h00, state=IDLE, counter=0, last-served=1.
- FSM states are IDLE, STRB, END and HOLD.
- IDLE
  - With no request, remain in IDLE.
  - With a request: select the winner, latch its wr, addr and wdata, drive addr, enable the data driver if wr=1, then go to STRB.
- STRB
  - Assert ior_ (read) or iow_ (write) low and count.
  - After STROBE_CYCLES cycles low, go to END.
- END
  - Deassert the strobe.
  - For a read, capture data into the winner's rdata at this edge.
  - Assert the winner's ack; update last-served; go to HOLD.
- HOLD
  - Deassert ack and release the data driver (Z).
  - Return to IDLE.
- Arbitration is evaluated only in IDLE.
  - Only one req high: that master wins.
  - Both high: the winner depends on the Configuration macro.
- If req is still high in the cycle after its ack, it is a new request (back-to-back access).
- If req is dropped mid-transaction, the access completes and ack still pulses; no abort path exists.
- A request raised during STRB, END or HOLD waits for IDLE.
- addr holds its last value between transactions; only data is released.
- Reset mid-transaction: strobes go high and the data driver turns off immediately (asynchronously). No ack is issued and the access is lost; the requester must re-issue after reset_ rises.
- ior_ and iow_ are never low simultaneously. data is never driven while ior_ is low.

## Timing
- Edge 0 samples req in IDLE. addr is valid from edge 0, and for a write data is driven from edge 0.
- Strobe is low from edge 1 to edge 1+S, where S = STROBE_CYCLES. Addr and write data are stable one full cycle before the strobe falls.
- Read data is sampled at edge 1+S, the edge on which the strobe rises.
- ack is high from edge 1+S to edge 2+S. rdata is valid in the same cycle as ack.
- Data is released at edge 2+S, and the FSM is back in IDLE at edge 2+S.
- The earliest next grant is edge 3+S, giving a throughput of one access per 3+S cycles (4 cycles with the default).

## Configuration
- IOARB_RR_EN defined: round-robin. When both masters request in IDLE, the master other than last-served wins. Last-served resets to 1, so master 0 wins the first contention.
- IOARB_RR_EN undefined: fixed priority. Master 0 always wins contention, and master 1 may starve. The last-served register is not implemented.

## Test plan
- Reset: assert reset_=0 mid-idle -> ior_=iow_=1, data=Z, addr=0000, ack0=ack1=0, rdata0=rdata1=00.
- Read, master 0, addr0=0101, bus device returns 5A while ior_ low, S=1:
  - ior_ is low exactly 1 cycle and iow_ stays 1.
  - ack0 pulses at edge 2 and rdata0=5A.
  - ack1 stays 0 and rdata1 is unchanged.
- Write, master 1, addr1=0121, wdata1=C3, S=3:
  - addr=0121 and data=C3 from edge 0 through edge 5, with iow_ low for edges 1–4.
  - ack1 pulses at edge 4; data is Z after edge 5.
- Contention, req0=req1=1 held, reads:
  - With IOARB_RR_EN, grants go 0,1,0,1 at 4-cycle spacing.
  - Without it, all grants go to master 0 and ack1 never pulses.
- Reset during STRB of a write:
  - iow_ returns to 1 and data goes to Z before the next clock edge, and no ack is issued.
  - After reset_=1 with req still high, the access restarts from IDLE and completes.
- req0 dropped at edge 1 of a read: the access still completes, ack0 pulses at edge 2 and rdata0 is updated.
